arch_state_dumper: RTL

//  Captures the architectural state of one Rocket tile and streams it out as 64-bit words in loadarch

---
 rtl/arch_dump_pkg.sv | 33 +++
 rtl/arch_dump_out_reg.sv | 57 +++++
 rtl/arch_state_dumper.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/arch_dump_pkg.sv
// Shared definitions for the architectural state dumper.
//  - arch_dump_state_e : dump sequencer states
//  - word counts per section and the total dump length
//  - loadarch CSR word positions used by the consumer
// Build option: ARCH_DUMP_FPR_EN adds the 32 FPR words to the dump.
package arch_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_SNAP,
        ST_CSR,
        ST_XPR,
        ST_FPR,
        ST_DONE
    } arch_dump_state_e;

    localparam int NUM_CSR_WORDS = 28;
    localparam int NUM_XPR       = 32;
    localparam int NUM_FPR       = 32;

    // Position of selected CSR words within the CSR section of the dump.
    localparam int IDX_PC       = 0;
    localparam int IDX_PRV      = 1;
    localparam int IDX_MTIMECMP = 27;

`ifdef ARCH_DUMP_FPR_EN
    localparam int TOTAL_WORDS = NUM_CSR_WORDS + NUM_XPR + NUM_FPR;
`else
    localparam int TOTAL_WORDS = NUM_CSR_WORDS + NUM_XPR;
`endif

endpackage

// File: rtl/arch_dump_out_reg.sv
// One-entry output register for the dump stream.
//  clock, reset        : clock, async active-high reset
//  clear               : restart the word index at 0 (start of a dump)
//  load, load_data,
//  load_last           : write a new word into the register
//  out_ready           : sink accepts the presented word
//  out_valid, out_data,
//  out_index, out_last : presented word and its position in the dump
//  free                : register can take a load this cycle (empty or draining)
module arch_dump_out_reg #(
    parameter int XLEN  = 64,
    parameter int IDX_W = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [XLEN-1:0]  load_data,
    input  logic             load_last,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_data,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             free
);

    logic xfer;

    assign xfer = out_valid && out_ready;
    assign free = !out_valid || out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            // Index tracks accepted words, so it is the position of whatever is presented.
            if (clear)
                out_index <= '0;
            else if (xfer)
                out_index <= out_index + 1'b1;

            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
                out_last  <= load_last;
            end else if (xfer) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/arch_state_dumper.sv
// Architectural state dumper for one tile: halts the core, snapshots the
// CSRs, reads the integer (and optionally FP) regfile, and streams 64-bit
// words in loadarch field order over valid/ready.
//  clock, reset             : clock, async active-high reset
//  dump_req                 : start pulse, ignored while busy
//  core_halt, core_quiesced : halt request / core drained acknowledgement
//  csr_vec                  : NUM_CSR packed CSR words
//  xpr_ren/raddr/rdata      : integer regfile read port (1-cycle latency)
//  fpr_ren/raddr/rdata      : FP regfile read port (ARCH_DUMP_FPR_EN only)
//  out_valid/ready/data/
//  out_index/out_last       : dump stream
//  busy, dump_done          : status
// Build option: ARCH_DUMP_FPR_EN enables the FPR section and fpr_* ports.
module arch_state_dumper
    import arch_dump_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int NUM_CSR = NUM_CSR_WORDS,
    parameter int IDX_W   = 7
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    dump_req,
    output logic                    core_halt,
    input  logic                    core_quiesced,
    input  logic [NUM_CSR*XLEN-1:0] csr_vec,
    output logic                    xpr_ren,
    output logic [4:0]              xpr_raddr,
    input  logic [XLEN-1:0]         xpr_rdata,
`ifdef ARCH_DUMP_FPR_EN
    output logic                    fpr_ren,
    output logic [4:0]              fpr_raddr,
    input  logic [XLEN-1:0]         fpr_rdata,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_data,
    output logic [IDX_W-1:0]        out_index,
    output logic                    out_last,
    output logic                    busy,
    output logic                    dump_done
);

    localparam logic [5:0] CSR_LAST = 6'(NUM_CSR - 1);
    localparam logic [5:0] REG_LAST = 6'd31;
    localparam logic [5:0] REG_END  = 6'd32;

    arch_dump_state_e state, state_nxt;
    logic [5:0]       cnt, cnt_nxt;     // CSR word or register number within a section
    logic             inflight;         // regfile read issued last cycle, data arriving now
    logic             rd_issue;
    logic [XLEN-1:0]  snap [NUM_CSR];

    logic             ld, ld_last, clear, free;
    logic [XLEN-1:0]  ld_data;

    assign busy      = (state != ST_IDLE);
    assign dump_done = (state == ST_DONE);
    assign core_halt = busy && (state != ST_DONE);

`ifdef ARCH_DUMP_FPR_EN
    assign rd_issue = xpr_ren || fpr_ren;
`else
    assign rd_issue = xpr_ren;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            inflight <= rd_issue;
        end
    end

    // Snapshot is only consumed after SNAP, so it needs no reset.
    always_ff @(posedge clock) begin
        if (state == ST_SNAP)
            for (int k = 0; k < NUM_CSR; k++)
                snap[k] <= csr_vec[k*XLEN +: XLEN];
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ld        = 1'b0;
        ld_data   = '0;
        ld_last   = 1'b0;
        clear     = 1'b0;
        xpr_ren   = 1'b0;
        xpr_raddr = cnt[4:0];
`ifdef ARCH_DUMP_FPR_EN
        fpr_ren   = 1'b0;
        fpr_raddr = cnt[4:0];
`endif
        case (state)
            ST_IDLE: if (dump_req) state_nxt = ST_HALT;
            ST_HALT: if (core_quiesced) state_nxt = ST_SNAP;
            ST_SNAP: begin
                clear     = 1'b1;
                cnt_nxt   = '0;
                state_nxt = ST_CSR;
            end
            ST_CSR: if (free) begin
                ld      = 1'b1;
                ld_data = snap[cnt[4:0]];
                cnt_nxt = cnt + 6'd1;
                if (cnt == CSR_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_XPR;
                end
            end
            ST_XPR: begin
                if (inflight) begin
                    // A read is only issued when the register will be empty now.
                    ld      = 1'b1;
                    ld_data = xpr_rdata;
                    cnt_nxt = cnt + 6'd1;
`ifdef ARCH_DUMP_FPR_EN
                    if (cnt == REG_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_FPR;
                    end
`else
                    ld_last = (cnt == REG_LAST);
`endif
                end else if (cnt == '0) begin
                    // x0 is hardwired zero: emitted without touching the regfile.
                    if (free) begin
                        ld      = 1'b1;
                        cnt_nxt = 6'd1;
                    end
                end else if (cnt < REG_END && free) begin
                    xpr_ren = 1'b1;
                end
`ifndef ARCH_DUMP_FPR_EN
                if (out_valid && out_ready && out_last) state_nxt = ST_DONE;
`endif
            end
`ifdef ARCH_DUMP_FPR_EN
            ST_FPR: begin
                if (inflight) begin
                    ld      = 1'b1;
                    ld_data = fpr_rdata;
                    ld_last = (cnt == REG_LAST);
                    cnt_nxt = cnt + 6'd1;
                end else if (cnt < REG_END && free) begin
                    fpr_ren = 1'b1;
                end
                if (out_valid && out_ready && out_last) state_nxt = ST_DONE;
            end
`endif
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    arch_dump_out_reg #(
        .XLEN  (XLEN),
        .IDX_W (IDX_W)
    ) u_out_reg (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .load      (ld),
        .load_data (ld_data),
        .load_last (ld_last),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .free      (free)
    );

endmodule
